fma16_sched: RTL and testbench
==============================

Name: fma16_sched

Overview:
- Round-robin scheduler that shares one fixed-latency fma16 datapath between two requesters.
- Each requester presents operands and op controls with a valid/ready handshake.
- The scheduler registers the winning operation and drives it into the datapath.
- It tracks ownership through a LAT-deep tag pipeline and routes each result and its flags back to the owning requester as a one-cycle response.

Parameters:
- LAT, 3, datapath latency in cycles from fu_valid to fu_res; legal range 1..8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  bit i: requester i presents an operation
- req_ready  out  2  bit i: requester i is granted this cycle
- req_x, req_y, req_z  in  2x16 each  per-requester operands; [15:0]=req0, [31:16]=req1
- req_ctl  in  2x4  per-requester {mul, add, negp, negz}
- fu_valid  out  1  operation issued to datapath this cycle
- fu_x, fu_y, fu_z  out  16 each  issued operands
- fu_mul, fu_add, fu_negp, fu_negz  out  1 each  issued controls
- fu_res  in  16  datapath result, valid exactly LAT cycles after fu_valid
- fu_flags  in  4  datapath flags {invalid, overflow, underflow, inexact}, same timing as fu_res
- rsp_valid  out  2  bit i: response for requester i
- rsp_res  out  16  response result (shared bus)
- rsp_flags  out  4  response flags
- busy  out  1  any operation in flight (issue register or tag pipeline)

Behaviour:
- Reset:
  - all outputs 0; rr pointer = 0 (req0 has priority).
  - issue register and every tag-pipeline stage marked invalid.
  - Reset mid-operation discards all in-flight operations; no rsp_valid is produced for them.
- Arbitration (combinational, no dependence on req_ready):
  - Exactly one valid: that requester is granted.
  - Both valid: the requester named by the rr pointer is granted.
  - None valid: no grant.
  - req_ready is one-hot or zero.
  - Accept = req_valid[i] & req_ready[i]. One accept maximum per cycle, with no bubbles: back-to-back accepts are allowed every cycle.
- RR pointer:
  - updates only on an accept, to the non-granted requester.
  - Alternates strictly under continuous contention.
- Issue:
  - On accept, the operands and controls of the winner are registered along with tag = winner index.
  - The next cycle, fu_valid=1 with those registered values.
  - fu_valid is 0 in any cycle following a cycle with no accept.
  - fu_* operand outputs hold their last value when fu_valid=0.
- Tag pipeline:
  - LAT stages of {valid, tag}; stage 0 loads {fu_valid, issue tag} each cycle and shifts by one every cycle (no stall).
  - Stage LAT-1 being valid marks the cycle in which fu_res/fu_flags belong to that tag.
- Response:
  - In the cycle after stage LAT-1 is valid, rsp_valid[tag]=1 for exactly one cycle, with rsp_res/rsp_flags registered from fu_res/fu_flags.
  - Otherwise rsp_valid=0 and rsp_res/rsp_flags hold their last value.
  - Requesters must accept responses; there is no response backpressure.
- Latency: accept in cycle N -> fu_valid in N+1 -> rsp_valid in N+LAT+2.
  - Responses return in issue order and are never reordered or lost.
- busy = issue-register valid | OR of tag-pipeline valid bits.
  - Excludes a response sitting in the output register that cycle.
- Simultaneous events: accept, issue, shift and response can all occur in the same cycle, with no interference.
- Controls pass through unchanged.
  - mul=0 / add=0 semantics (y treated as 1.0, z treated as 0) are owned by the datapath.
  - The scheduler never modifies operands.

Test Plan:
- Reset then single request: req0 x=3C00 y=4000 z=3C00 ctl=1100; the model returns 4200 at LAT=3 -> req_ready[0]=1 in cycle 0, fu_valid in cycle 1, rsp_valid=01 with rsp_res=4200, flags=0000 in cycle 5; busy high in cycles 1-4.
- Continuous contention, both valid for 6 cycles -> grants 0,1,0,1,0,1; fu_valid high for 6 consecutive cycles; rsp_valid sequence 01,10,01,10,01,10 in cycles 5-10, each with the matching result.
- req1 alone for 3 cycles, then both valid -> req1 granted 3 times, the rr pointer then favours req0, so the next contended grant goes to req0.
- Flags routing: the model returns fu_flags=1000 with result 7E00 for req1's op (x=7C00 y=0000 z=0000) -> rsp_valid=10, rsp_res=7E00, rsp_flags=1000; no response asserted for req0.
- Reset asserted for 1 cycle while 3 ops are in flight -> no rsp_valid afterwards; busy=0 and rr=0 after reset; a new req1 request completes normally in LAT+2 cycles.
- Rebuild with LAT=1: accept at cycle 0 -> rsp at cycle 3; interleaved gaps in req_valid produce matching fu_valid bubbles and response bubbles.

Source files
------------

// File: rtl/fma16_sched.sv
// fma16_sched: round-robin scheduler sharing one fixed-latency fma16 datapath
// between two requesters.
//
// Each cycle at most one requester is accepted. Its operation goes into an issue
// register and is driven into the datapath on the next cycle. A LAT-deep {valid, tag}
// pipeline follows each operation through the datapath. One cycle after the operation
// leaves the datapath, its result and flags are returned to the requester that sent it
// as a one-cycle response.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   req_valid/ready     per-requester handshake (bit i = requester i)
//   req_x/y/z           per-requester operands, [15:0]=req0, [31:16]=req1
//   req_ctl             per-requester {mul, add, negp, negz}, [3:0]=req0, [7:4]=req1
//   fu_valid, fu_*      operation issued to the datapath
//   fu_res, fu_flags    datapath result/flags, valid LAT cycles after fu_valid
//   rsp_valid           one-hot response strobe (bit i = requester i)
//   rsp_res, rsp_flags  response payload; holds its value between responses
//   busy                an operation is in the issue register or the tag pipeline
module fma16_sched #(
  parameter int unsigned LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  input  logic [31:0] req_z,
  input  logic [7:0]  req_ctl,
  output logic        fu_valid,
  output logic [15:0] fu_x,
  output logic [15:0] fu_y,
  output logic [15:0] fu_z,
  output logic        fu_mul,
  output logic        fu_add,
  output logic        fu_negp,
  output logic        fu_negz,
  input  logic [15:0] fu_res,
  input  logic [3:0]  fu_flags,
  output logic [1:0]  rsp_valid,
  output logic [15:0] rsp_res,
  output logic [3:0]  rsp_flags,
  output logic        busy
);

  // Round-robin pointer: names the requester that wins when both are valid.
  logic rr_q, rr_d;

  // Arbitration results.
  logic [1:0] grant;
  logic       accept;
  logic       win;

  // Issue register.
  logic        iss_v_q;
  logic        iss_tag_q;
  logic [15:0] iss_x_q, iss_y_q, iss_z_q;
  logic [3:0]  iss_ctl_q;

  // Tag pipeline: one {valid, tag} pair per datapath stage.
  logic [LAT-1:0] tv_q, tv_d;
  logic [LAT-1:0] tt_q, tt_d;

  // Response register.
  logic [1:0]  rsp_v_q, rsp_v_d;
  logic [15:0] rsp_res_q;
  logic [3:0]  rsp_flags_q;

  // State register for the arbiter pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Pointer next state: after an accept, priority passes to the other requester.
  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = ~win;
    end
  end

  // Grant decode; never looks at req_ready, so there is no combinational loop.
  always_comb begin
    grant = 2'b00;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    accept = |grant;
    win    = grant[1];
  end

  assign req_ready = grant;

  // The issue register loads on every accept. Its operands hold otherwise, so fu_*
  // keeps its last value during bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      iss_v_q   <= 1'b0;
      iss_tag_q <= 1'b0;
      iss_x_q   <= '0;
      iss_y_q   <= '0;
      iss_z_q   <= '0;
      iss_ctl_q <= '0;
    end else begin
      iss_v_q <= accept;
      if (accept) begin
        iss_tag_q <= win;
        iss_x_q   <= win ? req_x[31:16] : req_x[15:0];
        iss_y_q   <= win ? req_y[31:16] : req_y[15:0];
        iss_z_q   <= win ? req_z[31:16] : req_z[15:0];
        iss_ctl_q <= win ? req_ctl[7:4] : req_ctl[3:0];
      end
    end
  end

  assign fu_valid = iss_v_q;
  assign fu_x     = iss_x_q;
  assign fu_y     = iss_y_q;
  assign fu_z     = iss_z_q;
  assign fu_mul   = iss_ctl_q[3];
  assign fu_add   = iss_ctl_q[2];
  assign fu_negp  = iss_ctl_q[1];
  assign fu_negz  = iss_ctl_q[0];

  // The tag pipeline shifts every cycle. It never stalls, because the datapath never
  // stalls.
  always_comb begin
    tv_d    = '0;
    tt_d    = '0;
    tv_d[0] = iss_v_q;
    tt_d[0] = iss_tag_q;
    for (int unsigned i = 1; i < LAT; i++) begin
      tv_d[i] = tv_q[i-1];
      tt_d[i] = tt_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tv_q <= '0;
      tt_q <= '0;
    end else begin
      tv_q <= tv_d;
      tt_q <= tt_d;
    end
  end

  // The last stage marks the cycle in which fu_res belongs to its tag.
  always_comb begin
    rsp_v_d = 2'b00;
    if (tv_q[LAT-1]) begin
      rsp_v_d = tt_q[LAT-1] ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_v_q     <= 2'b00;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      rsp_v_q <= rsp_v_d;
      if (tv_q[LAT-1]) begin
        rsp_res_q   <= fu_res;
        rsp_flags_q <= fu_flags;
      end
    end
  end

  assign rsp_valid = rsp_v_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_flags = rsp_flags_q;

  // A response waiting in the output register does not count as in flight.
  assign busy = iss_v_q | (|tv_q);

endmodule

// File: tb/tb_fma16_sched.sv
// Testbench for fma16_sched. A stub datapath with latency LAT computes a deterministic
// result for each operation. The reference model tracks the round-robin priority and a
// queue of expected responses, each stamped with the cycle in which it must appear.
module tb_fma16_sched #(
  parameter int LAT = 3
);

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_x, req_y, req_z;
  logic [7:0]  req_ctl;
  logic        fu_valid;
  logic [15:0] fu_x, fu_y, fu_z;
  logic        fu_mul, fu_add, fu_negp, fu_negz;
  logic [15:0] fu_res;
  logic [3:0]  fu_flags;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_res;
  logic [3:0]  rsp_flags;
  logic        busy;

  always #5 clk = ~clk;

  fma16_sched #(.LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_z     (req_z),
    .req_ctl   (req_ctl),
    .fu_valid  (fu_valid),
    .fu_x      (fu_x),
    .fu_y      (fu_y),
    .fu_z      (fu_z),
    .fu_mul    (fu_mul),
    .fu_add    (fu_add),
    .fu_negp   (fu_negp),
    .fu_negz   (fu_negz),
    .fu_res    (fu_res),
    .fu_flags  (fu_flags),
    .rsp_valid (rsp_valid),
    .rsp_res   (rsp_res),
    .rsp_flags (rsp_flags),
    .busy      (busy)
  );

  // Stand-in for the fma16 datapath. Two known cases return real fp16 answers; any
  // other operation returns an arbitrary operand-dependent value.
  function automatic logic [19:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] z, input logic [3:0] c);
    logic [15:0] r;
    if (x == 16'h3C00 && y == 16'h4000 && z == 16'h3C00 && c == 4'b1100)
      return {4'b0000, 16'h4200};
    if (x == 16'h7C00 && y == 16'h0000 && z == 16'h0000)
      return {4'b1000, 16'h7E00};
    r = x ^ {y[7:0], y[15:8]} ^ (z + {12'h0, c});
    return {r[3:0] ^ c, r};
  endfunction

  // Stub datapath pipeline: fu_res is valid exactly LAT cycles after fu_valid.
  logic        dp_v   [LAT];
  logic [19:0] dp_out [LAT];
  always @(posedge clk) begin
    dp_v[0]   <= fu_valid;
    dp_out[0] <= ref_op(fu_x, fu_y, fu_z, {fu_mul, fu_add, fu_negp, fu_negz});
    for (int i = 1; i < LAT; i++) begin
      dp_v[i]   <= dp_v[i-1];
      dp_out[i] <= dp_out[i-1];
    end
  end
  assign fu_res   = dp_v[LAT-1] ? dp_out[LAT-1][15:0]  : 16'hDEAD;
  assign fu_flags = dp_v[LAT-1] ? dp_out[LAT-1][19:16] : 4'hF;

  // ---------------- reference model state ----------------
  typedef struct {
    int          acc;
    int          due;
    int          req;
    logic [15:0] res;
    logic [3:0]  fl;
  } exp_t;

  exp_t        q[$];
  bit          mrr;
  bit          exp_fu_v;
  logic [15:0] exp_x, exp_y, exp_z;
  logic [3:0]  exp_ctl;
  logic [15:0] last_res;
  logic [3:0]  last_fl;
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] z, input logic [3:0] c);
    req_x[16*i +: 16] = x;
    req_y[16*i +: 16] = y;
    req_z[16*i +: 16] = z;
    req_ctl[4*i +: 4] = c;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
  endtask

  // One clock cycle: check the DUT against the model mid-cycle, then advance the model
  // across the rising edge.
  task automatic tick();
    logic [1:0] g;
    int         w;
    bit         bz;
    exp_t       e;
    logic [19:0] r;
    @(negedge clk);
    if (!reset) begin
      if (req_valid == 2'b11) g = mrr ? 2'b10 : 2'b01;
      else g = req_valid;
      check("req_ready", 32'(req_ready), 32'(g));
      check("fu_valid", 32'(fu_valid), 32'(exp_fu_v));
      check("fu_x", 32'(fu_x), 32'(exp_x));
      check("fu_y", 32'(fu_y), 32'(exp_y));
      check("fu_z", 32'(fu_z), 32'(exp_z));
      check("fu_ctl", 32'({fu_mul, fu_add, fu_negp, fu_negz}), 32'(exp_ctl));
      bz = 0;
      foreach (q[k]) if (q[k].acc < cyc && cyc < q[k].due) bz = 1;
      check("busy", 32'(busy), 32'(bz));
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(1) << e.req);
        last_res = e.res;
        last_fl  = e.fl;
      end else begin
        check("rsp_valid", 32'(rsp_valid), 32'(0));
      end
      check("rsp_res", 32'(rsp_res), 32'(last_res));
      check("rsp_flags", 32'(rsp_flags), 32'(last_fl));
      if (g != 2'b00) begin
        w       = g[1] ? 1 : 0;
        exp_x   = req_x[16*w +: 16];
        exp_y   = req_y[16*w +: 16];
        exp_z   = req_z[16*w +: 16];
        exp_ctl = req_ctl[4*w +: 4];
        r       = ref_op(exp_x, exp_y, exp_z, exp_ctl);
        q.push_back('{acc: cyc, due: cyc + LAT + 2, req: w, res: r[15:0], fl: r[19:16]});
        exp_fu_v = 1;
        mrr      = (w == 0);
      end else begin
        exp_fu_v = 0;
      end
    end
    @(posedge clk);
    if (reset) begin
      q.delete();
      mrr      = 0;
      exp_fu_v = 0;
      exp_x    = '0;
      exp_y    = '0;
      exp_z    = '0;
      exp_ctl  = '0;
      last_res = '0;
      last_fl  = '0;
    end
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    req_valid = 2'b00;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_x     = '0;
    req_y     = '0;
    req_z     = '0;
    req_ctl   = '0;
    tick();
    tick();
    reset = 1'b0;
    idle(2);

    // Single request from req0: 1.0 * 2.0 + 1.0 = 3.0 (4200).
    set_req(0, 16'h3C00, 16'h4000, 16'h3C00, 4'b1100);
    req_valid = 2'b01;
    tick();
    idle(LAT + 4);

    // Continuous contention for 6 cycles.
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      rand_req(0);
      rand_req(1);
      tick();
    end
    idle(LAT + 4);

    // req1 alone for 3 cycles, then both valid.
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      rand_req(1);
      tick();
    end
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      rand_req(0);
      rand_req(1);
      tick();
    end
    idle(LAT + 4);

    // Flags routing: inf * 0 is invalid and gives a quiet NaN.
    set_req(1, 16'h7C00, 16'h0000, 16'h0000, 4'b1100);
    req_valid = 2'b10;
    tick();
    idle(LAT + 4);

    // Reset with three ops in flight (grants 0,1,0 leave priority on req1).
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      rand_req(0);
      rand_req(1);
      tick();
    end
    req_valid = 2'b00;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    idle(LAT + 3);
    // Priority must be back on req0.
    req_valid = 2'b11;
    rand_req(0);
    rand_req(1);
    tick();
    req_valid = 2'b10;
    rand_req(1);
    tick();
    idle(LAT + 4);

    // Random traffic with random gaps.
    for (int i = 0; i < 300; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      rand_req(0);
      rand_req(1);
      tick();
    end
    idle(LAT + 4);

    check("drained", 32'(q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
